// File: rtl/aes_cipher_serializer_if.sv
// aes_cipher_serializer_if: valid/ready byte stream carrying ciphertext bytes with an end-of-block marker
interface aes_cipher_serializer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/aes_cipher_serializer.sv
// aes_cipher_serializer: captures a 128-bit ciphertext on the rise of done and streams it out as 16 bytes
module aes_cipher_serializer #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [127:0]                  ciphertext,
  input  logic                          done,
  aes_cipher_serializer_if.master       m,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [CNT_W-1:0]              blocks_sent
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t             state_q;
  logic               done_q;
  logic [127:0]       sh_q;
  logic [3:0]         idx_q;
  logic               overrun_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_rise, xfer, fin;
  logic [127:0]       sh_next;
  assign done_rise = done & ~done_q;
  assign xfer      = (state_q == SEND) & m.m_ready;
  assign fin       = xfer & (idx_q == 4'd15);
  assign sh_next   = MSB_FIRST ? {sh_q[119:0], 8'h00} : {8'h00, sh_q[127:8]};
  // All outputs come straight from registers; nothing from ciphertext reaches m_data combinationally.
  assign m.m_data    = MSB_FIRST ? sh_q[127:120] : sh_q[7:0];
  assign m.m_valid   = (state_q == SEND);
  assign m.m_last    = (state_q == SEND) & (idx_q == 4'd15);
  assign busy        = (state_q == SEND);
  assign overrun     = overrun_q;
  assign blocks_sent = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      sh_q      <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= done;
      if (state_q == SEND && done_rise && !fin) overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;
      if (state_q == IDLE) begin
        if (done_rise) begin
          sh_q    <= ciphertext;
          idx_q   <= '0;
          state_q <= SEND;
        end
      end else if (xfer) begin
        // A block finishing on the same edge as a new done rise chains straight into the next one.
        if (fin) begin
          cnt_q <= cnt_q + 1'b1;
          if (done_rise) begin
            sh_q  <= ciphertext;
            idx_q <= '0;
          end else begin
            sh_q    <= sh_next;
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end else begin
          sh_q  <= sh_next;
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end
endmodule
